// File: rtl/ternary_serial_subtractor_pkg.sv
// Shared trit encoding and FSM state type for the ternary serial subtractor.
// Trit codes: 00=0, 01=1, 10=2, 11=illegal (decoded as 0).
package tern_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_0   = 2'b00;
  localparam trit_t TRIT_1   = 2'b01;
  localparam trit_t TRIT_2   = 2'b10;
  localparam trit_t TRIT_BAD = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic trit_t trit_decode(trit_t t);
    return (t == TRIT_BAD) ? TRIT_0 : t;
  endfunction

endpackage

// File: rtl/ternary_serial_subtractor_cell.sv
// One-trit subtractor: d = a - b - bin (mod 3), bout when the true result went negative.
// Illegal input codes are treated as 0 and reported on o_bad.
module tern_sub_cell
  import tern_pkg::*;
(
  input  logic [1:0] i_a_t,
  input  logic [1:0] i_b_t,
  input  logic       i_bin,
  output logic [1:0] o_d_t,
  output logic       o_bout,
  output logic       o_bad
);

  logic [1:0] w_a;
  logic [1:0] w_b;
  logic [2:0] w_sum;

  assign w_a = trit_decode(i_a_t);
  assign w_b = trit_decode(i_b_t);

  // Bias by +3 so the subtraction never goes negative: w_sum = a-b-bin+3 in 0..5.
  assign w_sum  = {1'b0, w_a} + 3'd3 - {1'b0, w_b} - {2'b00, i_bin};
  assign o_bout = (w_sum < 3'd3);
  assign o_d_t  = o_bout ? w_sum[1:0] : 2'(w_sum - 3'd3);
  assign o_bad  = (i_a_t == TRIT_BAD) || (i_b_t == TRIT_BAD);

endmodule

// File: rtl/ternary_serial_subtractor.sv
// Trit-serial a-b over NTRITS unbalanced-ternary trits, LSB first, one trit per clock.
// Optional illegal-code flag on err is built only when TERN_SUB_CHECK_EN is defined.
module ternary_serial_subtractor
  import tern_pkg::*;
#(
  parameter int NTRITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*NTRITS-1:0]   in_a,
  input  logic [2*NTRITS-1:0]   in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*NTRITS-1:0]   out_diff,
  output logic [1:0]            borrow_trit,
  output logic                  err
);

  localparam int W  = 2 * NTRITS;
  localparam int IW = (NTRITS > 1) ? $clog2(NTRITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NTRITS - 1);

  state_e        r_state;
  state_e        w_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_diff;
  logic [IW-1:0] r_idx;
  logic          r_borrow;

  logic [1:0]    w_d;
  logic          w_bout;
  logic          w_bad;
  logic          w_accept;
  logic          w_release;

  tern_sub_cell u_cell (
    .i_a_t  (r_a[1:0]),
    .i_b_t  (r_b[1:0]),
    .i_bin  (r_borrow),
    .o_d_t  (w_d),
    .o_bout (w_bout),
    .o_bad  (w_bad)
  );

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign w_accept    = in_valid && in_ready;
  assign w_release   = out_valid && out_ready;
  assign out_diff    = r_diff;
  assign borrow_trit = {1'b0, out_valid & r_borrow};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (r_idx == LAST) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operands shift right so the cell always sees the current trit in bits [1:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a      <= in_a;
      r_b      <= in_b;
      r_idx    <= '0;
      r_borrow <= 1'b0;
    end else if (r_state == RUN) begin
      r_a                 <= {2'b00, r_a[W-1:2]};
      r_b                 <= {2'b00, r_b[W-1:2]};
      r_diff[2*r_idx +: 2] <= w_d;
      r_borrow            <= w_bout;
      r_idx               <= r_idx + 1'b1;
    end
  end

`ifdef TERN_SUB_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst)                         r_err <= 1'b0;
    else if (w_release)              r_err <= 1'b0;
    else if (r_state == RUN && w_bad) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  logic w_unused;

  assign w_unused = w_bad;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_ternary_serial_subtractor.sv
// Self-checking bench for ternary_serial_subtractor: vector table plus scoreboard,
// with hand sequences for latency, backpressure and mid-run reset.
module tb_ternary_serial_subtractor;

  localparam int N = 8;
  localparam int W = 2 * N;
  localparam int MOD = 6561;
`ifdef TERN_SUB_CHECK_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_diff;
  logic [1:0]   borrow_trit;
  logic         err;

  ternary_serial_subtractor #(.NTRITS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_diff    (out_diff),
    .borrow_trit (borrow_trit),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic [1:0]   bor;
    logic         err;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int tval(input logic [W-1:0] x);
    int v;
    logic [1:0] t;
    v = 0;
    for (int i = N - 1; i >= 0; i--) begin
      t = x[2*i +: 2];
      v = v * 3 + ((t == 2'b11) ? 0 : int'(t));
    end
    return v;
  endfunction

  function automatic logic [W-1:0] tenc(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[2*i +: 2] = 2'(v % 3);
      v = v / 3;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] x);
    bit r;
    r = 1'b0;
    for (int i = 0; i < N; i++) if (x[2*i +: 2] == 2'b11) r = 1'b1;
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   vd;
    vd    = tval(a) - tval(b);
    e.bor = (vd < 0) ? 2'b01 : 2'b00;
    if (vd < 0) vd += MOD;
    e.diff = tenc(vd);
    e.err  = ERR_EXP && (has_bad(a) || has_bad(b));
    return e;
  endfunction

  function automatic logic [W-1:0] rand_trits();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] d, input logic [1:0] bor, input logic e);
    vec_t v;
    v.a = a; v.b = b; v.e.diff = d; v.e.bor = bor; v.e.err = e;
    return v;
  endfunction

  // Inputs change at posedge+1; outputs are consumed at the following negedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0h expected=none", out_diff);
      end else begin
        mon_e = sb.pop_front();
        chk("diff", 32'(out_diff), 32'(mon_e.diff));
        chk("borrow", 32'(borrow_trit), 32'(mon_e.bor));
        chk("err", 32'(err), 32'(mon_e.err));
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int n;
    n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready=0 expected=1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back(e);
      #1;
      in_valid = 1'b0;
      in_a = 16'($urandom);
      in_b = 16'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    vec_t vx, vy;
    int   c;
    int   seen;

    tbl[0] = mk(16'h0006, 16'h0004, 16'h0002, 2'b00, 1'b0);
    tbl[1] = mk(16'h0000, 16'h0001, 16'hAAAA, 2'b01, 1'b0);
    tbl[2] = mk(16'h5A96, 16'h5A96, 16'h0000, 2'b00, 1'b0);
    tbl[3] = mk(16'hAAAA, 16'h0000, 16'hAAAA, 2'b00, 1'b0);
    tbl[4] = mk(16'h0000, 16'hAAAA, 16'h0001, 2'b01, 1'b0);
    tbl[5] = mk(16'h0001, 16'h0002, 16'hAAAA, 2'b01, 1'b0);
    tbl[6] = mk(16'h0009, 16'h0006, 16'h0002, 2'b00, 1'b0);
    tbl[7] = mk(16'h0004, 16'h0001, 16'h0002, 2'b00, 1'b0);
    tbl[8] = mk(16'h0003, 16'h0000, 16'h0000, 2'b00, ERR_EXP);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_diff", 32'(out_diff), 32'd0);
    chk("rst_borrow", 32'(borrow_trit), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Latency from acceptance edge to out_valid.
    send(tbl[0].a, tbl[0].b, tbl[0].e);
    c = 0;
    while (!out_valid && c < 50) begin
      @(posedge clk); #1; c++;
    end
    chk("latency", 32'(c), 32'd8);
    drain();

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].e);
      drain();
      chk("err_cleared", 32'(err), 32'd0);
    end

    for (int r = 0; r < 6; r++) begin
      vx.a = rand_trits();
      vx.b = rand_trits();
      send(vx.a, vx.b, model(vx.a, vx.b));
      drain();
    end

    // Backpressure: result held, new operand ignored until release.
    vx = tbl[1];
    vy.a = rand_trits();
    vy.b = rand_trits();
    vy.e = model(vy.a, vy.b);
    out_ready = 1'b0;
    send(vx.a, vx.b, vx.e);
    c = 0;
    while (!out_valid && c < 50) begin
      @(posedge clk); #1; c++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    in_a = vy.a; in_b = vy.b; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_diff", 32'(out_diff), 32'(vx.e.diff));
      chk("bp_hold_borrow", 32'(borrow_trit), 32'(vx.e.bor));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_popped", 32'(sb.size()), 32'd0);
    @(posedge clk);
    sb.push_back(vy.e);
    #1;
    in_valid = 1'b0;
    chk("bp_pending_accepted", 32'(in_ready), 32'd0);
    drain();

    // Reset in the middle of RUN abandons the operation.
    send(tbl[3].a, tbl[3].b, tbl[3].e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_diff", 32'(out_diff), 32'd0);
    chk("midrst_borrow", 32'(borrow_trit), 32'd0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);

    send(tbl[0].a, tbl[0].b, tbl[0].e);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
